// File: rtl/lfsr_rng_pkg.sv
// Shared types and constants for the LFSR random-word arbiter.
// This package also holds the XNOR tap table that the LFSR uses.
package lfsr_rng_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSeed   = 2'd1,
    StWarmup = 2'd2,
    StServe  = 2'd3
  } state_e;

  localparam logic [31:0] DefaultSeed = 32'h0000_ACE1;

  function automatic int unsigned gnt_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Maximal-length XNOR taps (bit i set = stage i+1 feeds back), widths 3..32.
  function automatic logic [31:0] lfsr_taps(input int unsigned n);
    case (n)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci XNOR LFSR. The all-ones word is the lock-up state.
// done_o flags the step that brings the register back to the loaded seed.
module lfsr
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned NumBits = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               seed_dv_i,
  input  logic [NumBits-1:0] seed_data_i,
  output logic [NumBits-1:0] data_o,
  output logic               done_o
);

  localparam logic [31:0]        TapsFull = lfsr_taps(NumBits);
  localparam logic [NumBits-1:0] Taps     = TapsFull[NumBits-1:0];

  logic [NumBits-1:0] state_q, state_d, seed_q;

  assign state_d = {state_q[NumBits-2:0], ~^(state_q & Taps)};
  assign data_o  = state_q;
  assign done_o  = (state_d == seed_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
      seed_q  <= '0;
    end else if (seed_dv_i) begin
      state_q <= seed_data_i;
      seed_q  <= seed_data_i;
    end else if (en_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after ptr_i, wrapping around.
// A unit masked by mask_i is passed over only while another unit is asking.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [NumReq-1:0] mask_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  logic [NumReq-1:0] eff;
  logic [IdxW-1:0]   pos;
  logic              found;

  always_comb begin
    eff = req_i & ~mask_i;
    if (eff == '0) eff = req_i;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pos = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!found && eff[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Shares one XNOR LFSR among NUM_REQ requesters: seed, warm up, then grant one word per
// grant round-robin. The LFSR steps only on a grant, so every grant gets a fresh word.
module lfsr_rng_arbiter
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned  NUM_BITS     = 32,
  parameter int unsigned  NUM_REQ      = 4,
  parameter int unsigned  WARMUP       = 16,
  parameter logic [31:0]  DEFAULT_SEED = DefaultSeed,
  localparam int unsigned GNT_ID_W     = gnt_id_w(NUM_REQ)
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Start,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic [NUM_REQ-1:0]  i_Req,
  output logic [NUM_REQ-1:0]  o_Gnt,
  output logic [GNT_ID_W-1:0] o_Gnt_Id,
  output logic [NUM_BITS-1:0] o_Rand_Data,
  output logic                o_Rand_DV,
  output logic                o_Ready,
  output logic [15:0]         o_Wrap_Cnt
);

  localparam int unsigned        CntW     = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [NUM_BITS-1:0] SubSeed = DEFAULT_SEED[NUM_BITS-1:0];

  state_e              state_q;
  logic [NUM_BITS-1:0] seed_q;
  logic [CntW-1:0]     warm_cnt_q;
  logic [GNT_ID_W-1:0] ptr_q;

  logic [NUM_REQ-1:0]  win_gnt;
  logic [GNT_ID_W-1:0] win_idx;
  logic                win_valid;
  logic                grant;
  logic                lfsr_en;
  logic                lfsr_seed_dv;
  logic [NUM_BITS-1:0] lfsr_seed;
  logic [NUM_BITS-1:0] lfsr_data;
  logic                lfsr_done;

  rr_arbiter #(
    .NumReq (NUM_REQ),
    .IdxW   (GNT_ID_W)
  ) u_rr_arbiter (
    .req_i   (i_Req),
    .mask_i  (o_Gnt),
    .ptr_i   (ptr_q),
    .gnt_o   (win_gnt),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  // A reseed request pre-empts any grant in the same cycle.
  assign grant        = (state_q == StServe) && !i_Seed_DV && win_valid;
  assign lfsr_en      = (state_q == StWarmup) || grant;
  assign lfsr_seed_dv = (state_q == StSeed);
  assign lfsr_seed    = (&seed_q) ? SubSeed : seed_q;

  lfsr #(
    .NumBits (NUM_BITS)
  ) u_lfsr (
    .clk_i       (i_Clk),
    .rst_ni      (i_Rst_L),
    .en_i        (lfsr_en),
    .seed_dv_i   (lfsr_seed_dv),
    .seed_data_i (lfsr_seed),
    .data_o      (lfsr_data),
    .done_o      (lfsr_done)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      seed_q      <= SubSeed;
      warm_cnt_q  <= '0;
      ptr_q       <= '0;
      o_Gnt       <= '0;
      o_Gnt_Id    <= '0;
      o_Rand_Data <= '0;
      o_Rand_DV   <= 1'b0;
      o_Ready     <= 1'b0;
      o_Wrap_Cnt  <= '0;
    end else begin
      o_Gnt     <= '0;
      o_Rand_DV <= 1'b0;
      if (grant) begin
        o_Gnt       <= win_gnt;
        o_Gnt_Id    <= win_idx;
        o_Rand_Data <= lfsr_data;
        o_Rand_DV   <= 1'b1;
        ptr_q       <= (win_idx == GNT_ID_W'(NUM_REQ - 1)) ? '0 : win_idx + GNT_ID_W'(1);
      end
      if (lfsr_en && lfsr_done && (o_Wrap_Cnt != 16'hFFFF)) begin
        o_Wrap_Cnt <= o_Wrap_Cnt + 16'd1;
      end
      if (i_Seed_DV) begin
        seed_q  <= i_Seed_Data;
        state_q <= StSeed;
        o_Ready <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (i_Start) state_q <= StSeed;
          end
          StSeed: begin
            state_q    <= StWarmup;
            warm_cnt_q <= CntW'(WARMUP - 1);
          end
          StWarmup: begin
            if (warm_cnt_q == '0) begin
              state_q <= StServe;
              o_Ready <= 1'b1;
            end else begin
              warm_cnt_q <= warm_cnt_q - CntW'(1);
            end
          end
          StServe: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
